// File: rtl/ifmap_row_streamer.sv
// ifmap_row_streamer
// Reads IFMap pixels row by row from a synchronous single-port memory. It tags
// each word with first/last-of-row flags and pushes {first, last, pixel} into
// the IFMap FIFO under its ready handshake. A 2-entry queue absorbs the 1-cycle
// memory latency, which gives one word per cycle while the FIFO accepts.
// Optional feature: define IFMAP_STREAMER_ZERO_PAD_EN to add a 2-bit 'pad'
// input. Each row then gets pad zero words before and after it; these words are
// generated internally and do not read the memory.
module ifmap_row_streamer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int ROW_LEN_WIDTH = 6,
  parameter int ROWS_WIDTH    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROW_LEN_WIDTH-1:0] row_pitch,
  input  logic [ROWS_WIDTH-1:0]    num_rows,
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
  input  logic [1:0]               pad,
`endif
  output logic                     mem_ren,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     buf_ready,
  output logic                     buf_wen,
  output logic [DATA_WIDTH+1:0]    buf_din,
  output logic                     busy,
  output logic                     done
);

  // Column counter is one bit wider so that row_len plus both pad runs fits.
  localparam int CW = ROW_LEN_WIDTH + 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    row_base_q, row_base_d;
  logic [CW-1:0]            col_q, col_d;
  logic [ROWS_WIDTH-1:0]    row_q, row_d;
  logic [ROWS_WIDTH-1:0]    rows_q, rows_d;
  logic [ROW_LEN_WIDTH-1:0] len_q, len_d;
  logic [ROW_LEN_WIDTH-1:0] pitch_q, pitch_d;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
  logic [1:0]               pad_q, pad_d;
`endif
  logic [1:0]               occ_q, occ_d;
  logic [EW-1:0]            ent0_q, ent0_d;
  logic [EW-1:0]            ent1_q, ent1_d;
  logic                     inflight_q;
  logic                     inflight_pad_q;
  logic [1:0]               inflight_tag_q;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic [CW-1:0]            pad_w_s;
  logic [CW-1:0]            total_s;
  logic [CW-1:0]            pix_idx_s;
  logic [ADDR_WIDTH-1:0]    rd_addr_s;
  logic                     is_pad_s;
  logic                     first_s;
  logic                     last_s;
  logic [1:0]               tag_s;
  logic                     last_row_s;
  logic                     pop_s;
  logic [2:0]               pending_s;
  logic                     issue_s;
  logic                     accept_s;
  logic [EW-1:0]            push_word_s;

`ifdef IFMAP_STREAMER_ZERO_PAD_EN
  assign pad_w_s = CW'(pad_q);
`else
  assign pad_w_s = {CW{1'b0}};
`endif

  // Position of the current column within the padded row, and its tag
  assign total_s    = CW'(len_q) + pad_w_s + pad_w_s;
  assign is_pad_s   = (col_q < pad_w_s) || (col_q >= (pad_w_s + CW'(len_q)));
  assign pix_idx_s  = col_q - pad_w_s;
  assign rd_addr_s  = row_base_q + ADDR_WIDTH'(pix_idx_s);
  assign first_s    = (col_q == {CW{1'b0}});
  assign last_s     = (col_q == (total_s - CW'(1'b1)));
  assign tag_s      = {first_s, last_s};
  assign last_row_s = (row_q == (rows_q - ROWS_WIDTH'(1'b1)));

  // A pop happens whenever the head is valid and the FIFO has space.
  // Slot accounting counts both queued words and the word still in flight.
  assign pop_s     = rst && (occ_q != 2'd0) && buf_ready;
  assign pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s   = rst && (state_q == ST_STREAM) && (pending_s < 3'd2);
  assign accept_s  = (state_q == ST_IDLE) && start && !done_q;

  // Word returned this cycle: memory data, or zero for a pad slot
  assign push_word_s = {inflight_tag_q, (inflight_pad_q ? {DATA_WIDTH{1'b0}} : mem_rdata)};

  assign mem_ren  = issue_s && !is_pad_s;
  assign mem_addr = mem_ren ? rd_addr_s : {ADDR_WIDTH{1'b0}};
  assign buf_wen  = pop_s;
  assign buf_din  = pop_s ? ent0_q : {EW{1'b0}};
  assign busy     = busy_q;
  assign done     = done_q;

  // Next state, configuration latch and row/column walk
  always_comb begin
    state_d    = state_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    rows_d     = rows_q;
    len_d      = len_q;
    pitch_d    = pitch_q;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
    pad_d      = pad_q;
`endif
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          row_base_d = base_addr;
          col_d      = {CW{1'b0}};
          row_d      = {ROWS_WIDTH{1'b0}};
          rows_d     = num_rows;
          len_d      = row_len;
          pitch_d    = row_pitch;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
          pad_d      = pad;
`endif
          if ((row_len == {ROW_LEN_WIDTH{1'b0}}) || (num_rows == {ROWS_WIDTH{1'b0}})) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (issue_s) begin
          if (last_s) begin
            col_d      = {CW{1'b0}};
            row_base_d = row_base_q + ADDR_WIDTH'(pitch_q);
            row_d      = row_q + ROWS_WIDTH'(1'b1);
            if (last_row_s) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_STREAM;
            end
          end else begin
            col_d = col_q + CW'(1'b1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        // Finish when the last word leaves this cycle (or nothing was queued),
        // so done lands in the cycle right after the final write.
        if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_s))) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // Two-entry FIFO-order queue: entry 0 is the head
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({pop_s, inflight_q})
      2'b01: begin
        if (occ_q == 2'd0) begin
          ent0_d = push_word_s;
        end else begin
          ent1_d = push_word_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b10: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_word_s;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_word_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // State, counters, queue and in-flight tracking; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      row_base_q     <= {ADDR_WIDTH{1'b0}};
      col_q          <= {CW{1'b0}};
      row_q          <= {ROWS_WIDTH{1'b0}};
      rows_q         <= {ROWS_WIDTH{1'b0}};
      len_q          <= {ROW_LEN_WIDTH{1'b0}};
      pitch_q        <= {ROW_LEN_WIDTH{1'b0}};
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
      pad_q          <= 2'b00;
`endif
      occ_q          <= 2'd0;
      ent0_q         <= {EW{1'b0}};
      ent1_q         <= {EW{1'b0}};
      inflight_q     <= 1'b0;
      inflight_pad_q <= 1'b0;
      inflight_tag_q <= 2'b00;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_base_q     <= row_base_d;
      col_q          <= col_d;
      row_q          <= row_d;
      rows_q         <= rows_d;
      len_q          <= len_d;
      pitch_q        <= pitch_d;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
      pad_q          <= pad_d;
`endif
      occ_q          <= occ_d;
      ent0_q         <= ent0_d;
      ent1_q         <= ent1_d;
      inflight_q     <= issue_s;
      inflight_pad_q <= is_pad_s;
      inflight_tag_q <= tag_s;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_ifmap_row_streamer.sv
// Self-checking bench for ifmap_row_streamer: expected words and read
// addresses are queued when a job is issued, and a monitor checks them as the
// DUT emits them.
module tb_ifmap_row_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [5:0]  row_len;
  logic [5:0]  row_pitch;
  logic [5:0]  num_rows;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
  logic [1:0]  pad;
`endif
  logic        mem_ren;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        buf_ready;
  logic        buf_wen;
  logic [17:0] buf_din;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:1023];
  logic [17:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  int          wen_cycs[$];
  int          done_cycs[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        bp_en = 1'b0;
  int          bp_ph = 0;

  ifmap_row_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_len   (row_len),
    .row_pitch (row_pitch),
    .num_rows  (num_rows),
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
    .pad       (pad),
`endif
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .buf_ready (buf_ready),
    .buf_wen   (buf_wen),
    .buf_din   (buf_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Cycle counter: value k during the period following the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory model, contents mem[i] = i + 100
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 100);
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // FIFO-side ready: held high, or the 1,0,0,1 pattern when backpressure is on
  initial begin
    buf_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        buf_ready = (bp_ph == 0) || (bp_ph == 3);
        bp_ph = (bp_ph + 1) % 4;
      end else begin
        buf_ready = 1'b1;
        bp_ph = 0;
      end
    end
  end

  // Monitor: compares every write and every read address against the queues
  always @(negedge clk) begin
    if (buf_wen) begin
      wen_cycs.push_back(cyc);
      check("ready_at_wen", {31'd0, buf_ready}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: actual=%0h required=none", buf_din);
      end else begin
        check("buf_din", {14'd0, buf_din}, {14'd0, exp_q.pop_front()});
      end
    end
    if (mem_ren) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_read: actual=%0h required=none", mem_addr);
      end else begin
        check("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addr_q.pop_front()});
      end
    end
    if (done) done_cycs.push_back(cyc);
  end

  // Queue the expected words/addresses of a job, then pulse start for one cycle
  task automatic run_job(input logic [9:0] b, input logic [5:0] rl, input logic [5:0] pt,
                         input logic [5:0] nr, input int pd, output int c0);
    int tot;
    logic [9:0] a;
    logic [15:0] px;
    tot = (rl == 6'd0 || nr == 6'd0) ? 0 : int'(rl) + 2 * pd;
    for (int r = 0; r < int'(nr); r++) begin
      for (int c = 0; c < tot; c++) begin
        if (c < pd || c >= pd + int'(rl)) begin
          px = 16'd0;
        end else begin
          a = b + 10'(r * int'(pt) + (c - pd));
          exp_addr_q.push_back(a);
          px = 16'(a) + 16'd100;
        end
        exp_q.push_back({(c == 0), (c == tot - 1), px});
      end
    end
    @(posedge clk);
    #1;
    base_addr = b; row_len = rl; row_pitch = pt; num_rows = nr;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
    pad = 2'(pd);
`endif
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int n = 0;
    while (done_cycs.size() <= d0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cycs.size() <= d0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: actual=none required=done within %0d cycles", bound);
    end
  endtask

  task automatic check_job(input string nm, input int c0, input int w0, input int d0,
                           input int nw, input bit contiguous);
    int wn;
    wn = wen_cycs.size() - w0;
    check({nm, "_words"}, wn, nw);
    if (done_cycs.size() > d0) begin
      if (nw == 0) begin
        check({nm, "_done_cycle"}, done_cycs[d0] - c0, 2);
      end else if (wn == nw) begin
        check({nm, "_done_after_last"}, done_cycs[d0] - wen_cycs[w0 + nw - 1], 1);
        if (contiguous) begin
          check({nm, "_first_wen"}, wen_cycs[w0] - c0, 3);
          check({nm, "_no_bubbles"}, wen_cycs[w0 + nw - 1] - wen_cycs[w0], nw - 1);
        end
      end
    end
    check({nm, "_sb_empty"}, exp_q.size(), 0);
    check({nm, "_addr_empty"}, exp_addr_q.size(), 0);
    repeat (4) @(negedge clk);
    #1;
    check({nm, "_one_done"}, done_cycs.size() - d0, 1);
    check({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int c0, w0, d0, n;
    rst = 1'b0; start = 1'b0;
    base_addr = 10'd0; row_len = 6'd0; row_pitch = 6'd0; num_rows = 6'd0;
`ifdef IFMAP_STREAMER_ZERO_PAD_EN
    pad = 2'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_ren, mem_addr, buf_wen, buf_din, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic stream: 2 rows x 6 pixels, no backpressure
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd0, 6'd6, 6'd6, 6'd2, 0, c0);
    wait_done(d0, 200);
    check_job("basic", c0, w0, d0, 12, 1'b1);

    // Same job under 1,0,0,1 backpressure
    bp_en = 1'b1;
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd0, 6'd6, 6'd6, 6'd2, 0, c0);
    wait_done(d0, 300);
    bp_en = 1'b0;
    check_job("backpressure", c0, w0, d0, 12, 1'b0);

    // Single-pixel rows with address wrap: reads 1020, 0, 4
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd1020, 6'd1, 6'd4, 6'd3, 0, c0);
    wait_done(d0, 200);
    check_job("single_px", c0, w0, d0, 3, 1'b1);

    // Empty job; a start while busy and a start in the done cycle are ignored
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd0, 6'd3, 6'd3, 6'd0, 0, c0);
    base_addr = 10'd8; row_len = 6'd4; num_rows = 6'd2; start = 1'b1;
    @(negedge clk);
    check("empty_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("empty_done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0, 50);
    check_job("empty", c0, w0, d0, 0, 1'b1);

    // Reset after 5 writes, then a full job again
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd0, 6'd6, 6'd6, 6'd2, 0, c0);
    n = 0;
    while (wen_cycs.size() - w0 < 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {mem_ren, mem_addr, buf_wen, buf_din, busy, done}, 32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("reset_words", wen_cycs.size() - w0, 5);
    check("reset_no_done", done_cycs.size() - d0, 0);
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd0, 6'd6, 6'd6, 6'd2, 0, c0);
    wait_done(d0, 200);
    check_job("after_reset", c0, w0, d0, 12, 1'b1);

`ifdef IFMAP_STREAMER_ZERO_PAD_EN
    // Zero padding: pad=1, row_len=3 gives 5 words per row, 3 reads per row
    w0 = wen_cycs.size(); d0 = done_cycs.size();
    run_job(10'd16, 6'd3, 6'd3, 6'd2, 1, c0);
    wait_done(d0, 200);
    check_job("pad", c0, w0, d0, 10, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/ifmap_row_streamer.md
# ifmap_row_streamer

Upstream feeder for the processing element's IFMap circular buffer. Reads raw IFMap pixels row by row from a synchronous single-port memory. Tags each word with row-boundary flags and pushes the resulting DATA_WIDTH+2-bit words into the IFMap FIFO under its ready handshake. A 2-entry internal queue absorbs the 1-cycle memory read latency, so throughput is one word per cycle while the FIFO accepts.

## Interface

Parameters:
- DATA_WIDTH, 16, pixel width.
- ADDR_WIDTH, 10, memory address width.
- ROW_LEN_WIDTH, 6, width of row length and row pitch.
- ROWS_WIDTH, 6, width of row count.

Ports:
- clk  in  1  single clock; everything on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  address of pixel 0 of row 0; latched at start.
- row_len  in  ROW_LEN_WIDTH  pixels per row; latched at start.
- row_pitch  in  ROW_LEN_WIDTH  address distance between consecutive row starts; latched at start.
- num_rows  in  ROWS_WIDTH  rows to stream; latched at start.
- mem_ren  out  1  memory read enable.
- mem_addr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_ren.
- buf_ready  in  1  IFMap FIFO has space.
- buf_wen  out  1  FIFO write strobe.
- buf_din  out  DATA_WIDTH+2  {first_flag, last_flag, pixel}.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

## Operation

- States: IDLE, STREAM, DRAIN.
- IDLE:
  - start=1 latches the configuration and resets the row/column counters.
  - If row_len=0 or num_rows=0, go to DRAIN with nothing issued.
  - Otherwise go to STREAM.
- STREAM:
  - Issue a read at (row_base + col) when occupancy + in_flight − pop_this_cycle < 2.
  - col increments per read. At col = row_len−1, col returns to 0 and row_base increases by row_pitch.
  - After the read of the last pixel of the last row, go to DRAIN.
- DRAIN: wait until the queue is empty and nothing is in flight. Pulse done, then return to IDLE.
- Tags are computed at issue and travel with the read:
  - first pixel of a row: 2'b10
  - last pixel of a row: 2'b01
  - row_len=1: 2'b11
  - otherwise: 2'b00
- Queue: 2 entries, FIFO order. Returned data is pushed the cycle after mem_ren. The head is popped when buf_ready=1; a pop drives buf_wen=1 with buf_din = head.
- buf_wen is never asserted while buf_ready=0.
- No word is ever dropped or duplicated.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- busy=1 from the cycle after an accepted start through the done cycle inclusive.
- Reset mid-operation:
  - State goes to IDLE and the queue and counters clear.
  - The in-flight read is discarded.
  - No done pulse is produced.

## Timing

- Reset values: mem_ren=0, mem_addr=0, buf_wen=0, buf_din=0, busy=0, done=0.
- Start accepted in cycle 0. First mem_ren in cycle 1; data lands in the queue at the end of cycle 2; first buf_wen in cycle 3 if buf_ready=1.
- Steady state with buf_ready held at 1: one buf_wen per cycle with no bubbles, including across row boundaries.
- done is asserted in the cycle after the final buf_wen. For an empty job (row_len=0 or num_rows=0), done is asserted in cycle 2.
- A start coinciding with the done cycle is ignored.

## Configuration

- IFMAP_STREAMER_ZERO_PAD_EN:
  - Defined: adds input pad (2 bits, latched at start). Each row is emitted as pad zero words, then row_len memory pixels, then pad zero words.
  - Pad words are generated internally with no memory read. They share the queue slot accounting and take the first/last tags when pad>0.
  - Undefined: the pad port is absent and rows contain memory pixels only.

## Test plan

- Basic stream: base=0, row_len=6, pitch=6, rows=2, memory[i]=i+100, buf_ready=1 -> 12 consecutive buf_wen cycles starting at cycle 3. Tags per row are 10,00,00,00,00,01; pixels 100..111. done in the cycle after the 12th write.
- Backpressure: same job with buf_ready toggling 1,0,0,1 repeating -> the FIFO receives exactly 12 words in order, no buf_wen while buf_ready=0, and done only after the final write.
- Single-pixel rows and pitch: row_len=1, rows=3, pitch=4, base=1020 with ADDR_WIDTH=10 -> reads at 1020, 0, 4 (address wraps), all tags 2'b11.
- Empty job: num_rows=0 -> no mem_ren, no buf_wen, done in cycle 2. A start while busy is ignored.
- Reset mid-job: rst=0 asserted after 5 writes -> all outputs 0 next cycle and no done pulse. A new start then streams the full job correctly.
- With IFMAP_STREAMER_ZERO_PAD_EN, pad=1, row_len=3 -> each row is {10,0},{00,d0},{00,d1},{00,d2},{01,0} with 3 mem reads per row.
